// File: rtl/branch_resolve.sv
// Branch resolution unit for the decode stage.
// Picks each branch operand from the register file, the immediate or a
// forwarding source, evaluates the branch condition, stalls while a chosen
// forwarding source is not ready, and issues a registered one-cycle redirect.
module branch_resolve #(
    parameter int NUM_BITS = 32,
    parameter int NUM_FWD  = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic [2:0]                  br_op,
    input  logic [NUM_BITS-1:0]         rs_data,
    input  logic [NUM_BITS-1:0]         rt_data,
    input  logic [NUM_FWD-1:0]          rs_fwd_sel,
    input  logic [NUM_FWD-1:0]          rt_fwd_sel,
    input  logic [NUM_FWD*NUM_BITS-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]          fwd_ready,
    input  logic                        use_imm,
    input  logic [NUM_BITS-1:0]         sign_ext_imm,
    input  logic [NUM_BITS-1:0]         pc_plus4,
    input  logic                        clr_cnt,
    output logic                        stall_out,
    output logic                        redirect_valid,
    output logic [NUM_BITS-1:0]         redirect_target,
    output logic [CNT_BITS-1:0]         br_count,
    output logic [CNT_BITS-1:0]         taken_count
);

    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

    state_t state, state_next;

    logic [NUM_BITS-1:0] op_a, op_b;
    logic                a_pend, b_pend;
    logic                taken;
    logic                active, pending, resolve;
    logic [NUM_BITS-1:0] target;

    // Operand select: the lowest set select bit wins, so scan from the top down.
    always_comb begin
        op_a   = rs_data;
        a_pend = 1'b0;
        op_b   = rt_data;
        b_pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (rs_fwd_sel[i]) begin
                op_a   = fwd_data[i*NUM_BITS +: NUM_BITS];
                a_pend = ~fwd_ready[i];
            end
            if (rt_fwd_sel[i]) begin
                op_b   = fwd_data[i*NUM_BITS +: NUM_BITS];
                b_pend = ~fwd_ready[i];
            end
        end
        if (use_imm) begin
            op_b   = sign_ext_imm;
            b_pend = 1'b0;
        end
    end

    // Branch condition; the zero-compare ops look only at operand 1 as signed.
    always_comb begin
        taken = 1'b0;
        case (br_op)
            3'b000:  taken = (op_a == op_b);
            3'b001:  taken = (op_a != op_b);
            3'b010:  taken = op_a[NUM_BITS-1] | (op_a == '0);
            3'b011:  taken = ~op_a[NUM_BITS-1] & (op_a != '0);
            3'b100:  taken = op_a[NUM_BITS-1];
            3'b101:  taken = ~op_a[NUM_BITS-1];
            3'b110:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign target    = pc_plus4 + {sign_ext_imm[NUM_BITS-3:0], 2'b00};
    assign active    = valid_in & (state != FLUSH);
    assign pending   = a_pend | b_pend;
    assign resolve   = active & ~pending;
    assign stall_out = rst_n & active & pending;

    // Redirect is a straight decode of the FLUSH state, so it is registered.
    assign redirect_valid = (state == FLUSH);

    // Next-state logic; the FLUSH slot is squashed so always falls back to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE, WAIT: begin
                if (active && pending)
                    state_next = WAIT;
                else if (resolve && taken)
                    state_next = FLUSH;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Target register only follows taken resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            redirect_target <= '0;
        else if (resolve && taken)
            redirect_target <= target;
    end

    // Saturating performance counters; clear beats a coincident resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count    <= '0;
            taken_count <= '0;
        end else if (clr_cnt) begin
            br_count    <= '0;
            taken_count <= '0;
        end else if (resolve) begin
            if (br_count != CNT_MAX)
                br_count <= br_count + 1'b1;
            if (taken && (taken_count != CNT_MAX))
                taken_count <= taken_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: expected redirect targets go into
// a scoreboard queue when a taken branch is driven and are popped when the
// DUT pulses redirect_valid; counters are tracked by a saturating model.
module tb_branch_resolve;

    localparam int NB = 32;
    localparam int NF = 2;
    localparam int CB = 8;
    localparam logic [CB-1:0] CMAX = {CB{1'b1}};

    logic              clk;
    logic              rst_n;
    logic              valid_in;
    logic [2:0]        br_op;
    logic [NB-1:0]     rs_data, rt_data;
    logic [NF-1:0]     rs_fwd_sel, rt_fwd_sel;
    logic [NF*NB-1:0]  fwd_data;
    logic [NF-1:0]     fwd_ready;
    logic              use_imm;
    logic [NB-1:0]     sign_ext_imm;
    logic [NB-1:0]     pc_plus4;
    logic              clr_cnt;
    logic              stall_out;
    logic              redirect_valid;
    logic [NB-1:0]     redirect_target;
    logic [CB-1:0]     br_count, taken_count;

    int checks = 0;
    int errors = 0;
    logic [NB-1:0] sb_q[$];
    logic [CB-1:0] exp_br = '0;
    logic [CB-1:0] exp_tk = '0;

    typedef struct {
        logic [2:0]    op;
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic [NB-1:0] imm;
        logic          tk;
    } cond_t;

    branch_resolve #(.NUM_BITS(NB), .NUM_FWD(NF), .CNT_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .br_op(br_op),
        .rs_data(rs_data), .rt_data(rt_data), .rs_fwd_sel(rs_fwd_sel),
        .rt_fwd_sel(rt_fwd_sel), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
        .use_imm(use_imm), .sign_ext_imm(sign_ext_imm), .pc_plus4(pc_plus4),
        .clr_cnt(clr_cnt), .stall_out(stall_out), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .br_count(br_count),
        .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every redirect pulse must match a queued target.
    always @(negedge clk) begin
        if (rst_n && redirect_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_redirect target=%h (no taken branch queued)", redirect_target);
            end else begin
                logic [NB-1:0] exp_t;
                exp_t = sb_q.pop_front();
                if (redirect_target !== exp_t) begin
                    errors++;
                    $display("[TB] FAIL redirect_target got=%h exp=%h", redirect_target, exp_t);
                end
            end
        end
    end

    task automatic clear_inputs();
        valid_in     = 1'b0;
        br_op        = 3'b000;
        rs_data      = '0;
        rt_data      = '0;
        rs_fwd_sel   = '0;
        rt_fwd_sel   = '0;
        fwd_data     = '0;
        fwd_ready    = '1;
        use_imm      = 1'b0;
        sign_ext_imm = '0;
        pc_plus4     = '0;
        clr_cnt      = 1'b0;
    endtask

    task automatic model_resolve(input logic tk);
        if (exp_br != CMAX) exp_br = exp_br + 1'b1;
        if (tk && exp_tk != CMAX) exp_tk = exp_tk + 1'b1;
    endtask

    // Drive one register-file branch; called just after a rising edge.
    task automatic issue(input logic [2:0] op, input logic [NB-1:0] a,
                         input logic [NB-1:0] b, input logic [NB-1:0] imm,
                         input logic [NB-1:0] pc, input logic tk);
        br_op        = op;
        rs_data      = a;
        rt_data      = b;
        sign_ext_imm = imm;
        pc_plus4     = pc;
        valid_in     = 1'b1;
        if (tk) sb_q.push_back(pc + (imm << 2));
        @(posedge clk);
        model_resolve(tk);
        #1;
        valid_in = 1'b0;
        if (tk) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (br_count !== exp_br || taken_count !== exp_tk) begin
            errors++;
            $display("[TB] FAIL %s br_count=%h taken_count=%h exp %h %h",
                     name, br_count, taken_count, exp_br, exp_tk);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n      = 1'b0;
        valid_in   = 1'b1;
        rs_fwd_sel = 2'b01;
        fwd_ready  = 2'b00;
        #3;
        checks++;
        if (stall_out !== 1'b0 || redirect_valid !== 1'b0 || redirect_target !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs stall=%b rv=%b tgt=%h exp 0 0 0",
                     stall_out, redirect_valid, redirect_target);
        end
        check_counts("reset_counts");
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_beq_taken();
        br_op = 3'b000; rs_data = 32'd5; rt_data = 32'd5;
        pc_plus4 = 32'h100; sign_ext_imm = 32'd3; valid_in = 1'b1;
        sb_q.push_back(32'h10C);
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL beq_resolve_cycle stall=%b rv=%b exp 0 0", stall_out, redirect_valid);
        end
        @(posedge clk);
        model_resolve(1'b1);
        #1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL beq_pulse_missing pending=%0d exp 0", sb_q.size());
        end
        check_counts("beq_counts");
    endtask

    task automatic test_bne_fwd_priority();
        br_op = 3'b001; rs_fwd_sel = 2'b11; fwd_ready = 2'b11;
        fwd_data = {32'd9, 32'd7}; rt_data = 32'd7; valid_in = 1'b1;
        @(posedge clk);
        model_resolve(1'b0);
        #1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bne_no_pulse rv=%b exp 0", redirect_valid);
        end
        @(posedge clk);
        #1;
        check_counts("bne_counts");
    endtask

    task automatic test_stall_bgez();
        br_op = 3'b101; rs_fwd_sel = 2'b01; fwd_ready = 2'b00;
        fwd_data = {32'd0, 32'h8000_0000}; valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (stall_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_cycle%0d stall=%b exp 1", k, stall_out);
            end
            @(posedge clk);
            #1;
        end
        fwd_ready = 2'b01;
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release stall=%b exp 0", stall_out);
        end
        @(posedge clk);
        model_resolve(1'b0);
        #1;
        clear_inputs();
        @(posedge clk);
        #1;
        check_counts("bgez_counts");
    endtask

    task automatic test_use_imm();
        // Source 1 is not ready but use_imm overrides rt selection.
        br_op = 3'b000; rs_data = 32'hFFFF_FFF0; sign_ext_imm = 32'hFFFF_FFF0;
        rt_fwd_sel = 2'b10; fwd_ready = 2'b01; use_imm = 1'b1;
        pc_plus4 = 32'h2000; valid_in = 1'b1;
        sb_q.push_back(32'h2000 - 32'h40);
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL use_imm_no_stall stall=%b exp 0", stall_out);
        end
        @(posedge clk);
        model_resolve(1'b1);
        #1;
        clear_inputs();
        @(posedge clk);
        #1;
        check_counts("use_imm_counts");
    endtask

    task automatic test_conditions();
        cond_t tbl[12];
        tbl[0]  = '{3'b000, 32'd1,          32'd2, 32'd4,          1'b0};
        tbl[1]  = '{3'b001, 32'd1,          32'd2, 32'hFFFF_FFFF,  1'b1};
        tbl[2]  = '{3'b010, 32'd0,          32'd9, 32'd8,          1'b1};
        tbl[3]  = '{3'b010, 32'd1,          32'd0, 32'd8,          1'b0};
        tbl[4]  = '{3'b011, 32'd1,          32'd0, 32'd16,         1'b1};
        tbl[5]  = '{3'b011, 32'd0,          32'd0, 32'd16,         1'b0};
        tbl[6]  = '{3'b011, 32'h8000_0000,  32'd0, 32'd16,         1'b0};
        tbl[7]  = '{3'b100, 32'hFFFF_FFFF,  32'd0, 32'hFFFF_FFFE,  1'b1};
        tbl[8]  = '{3'b100, 32'd0,          32'd0, 32'd2,          1'b0};
        tbl[9]  = '{3'b101, 32'd0,          32'd5, 32'd100,        1'b1};
        tbl[10] = '{3'b110, 32'd3,          32'd4, 32'd7,          1'b1};
        tbl[11] = '{3'b111, 32'd3,          32'd3, 32'd7,          1'b0};
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, 32'h0040_0000 + i * 32'h40, tbl[i].tk);
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL cond_pulses_missing pending=%0d exp 0", sb_q.size());
        end
        check_counts("cond_counts");
    endtask

    task automatic test_jump_wrap_flush();
        br_op = 3'b110; pc_plus4 = 32'hFFFF_FFFC; sign_ext_imm = 32'd1; valid_in = 1'b1;
        sb_q.push_back(32'h0000_0000);
        @(posedge clk);
        model_resolve(1'b1);
        #1;
        // Squashed slot: a pending operand must not stall or count.
        br_op = 3'b000; rs_fwd_sel = 2'b01; fwd_ready = 2'b00;
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b0 || redirect_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_slot stall=%b rv=%b exp 0 1", stall_out, redirect_valid);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        check_counts("flush_counts");
    endtask

    task automatic test_saturation();
        int guard = 0;
        while ((exp_br != CMAX || exp_tk != CMAX) && guard < 600) begin
            issue(3'b110, 32'd0, 32'd0, guard, 32'h1000, 1'b1);
            guard++;
        end
        issue(3'b110, 32'd0, 32'd0, 32'd5, 32'h3000, 1'b1);
        checks++;
        if (br_count !== CMAX || taken_count !== CMAX) begin
            errors++;
            $display("[TB] FAIL saturate br=%h tk=%h exp %h %h", br_count, taken_count, CMAX, CMAX);
        end
        clr_cnt = 1'b1;
        issue(3'b110, 32'd0, 32'd0, 32'd6, 32'h3000, 1'b1);
        clr_cnt = 1'b0;
        exp_br  = '0;
        exp_tk  = '0;
        check_counts("clr_wins");
    endtask

    task automatic test_reset_mid_wait();
        issue(3'b110, 32'd0, 32'd0, 32'd9, 32'h5000, 1'b1);
        br_op = 3'b000; rs_fwd_sel = 2'b10; fwd_ready = 2'b00; valid_in = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_entered stall=%b exp 1", stall_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_br = '0;
        exp_tk = '0;
        checks++;
        if (stall_out !== 1'b0 || redirect_valid !== 1'b0 || redirect_target !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset stall=%b rv=%b tgt=%h exp 0 0 0",
                     stall_out, redirect_valid, redirect_target);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_counts("post_reset_counts");
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_bne_fwd_priority();
        test_stall_bgez();
        test_use_imm();
        test_conditions();
        test_jump_wrap_flush();
        test_saturation();
        test_reset_mid_wait();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain pending=%0d exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
